id_stage_p: RTL and testbench

ID_STAGE_P -- requirements
Module: id_stage_p

---
 rtl/id_stage_p.sv | 197 +++++++++++++++++++
 tb/tb_id_stage_p.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_p.sv
// Decode stage: control decode, register file with half-word writeback and bypass, one output register.
// Latency 1 cycle from accept to out_valid.
// Backpressure: in_ready drops while out_ready is low with out_valid set, on a load-use hazard, or during flush.
module id_stage_p #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int LINK_REG = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [31:0]       pc_plus_4,
    input  logic              interrupt,
    input  logic              wr,
    input  logic [3:0]        wr_dst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_opcode,
    output logic [3:0]        out_rs1,
    output logic [3:0]        out_rs2,
    output logic [3:0]        out_rd,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_imm,
    output logic [31:0]       out_pc_plus_4,
    output logic              out_interrupt,
    output logic [9:0]        out_ctrl,
    output logic [31:0]       branch_pc,
    output logic              branch_sel,
    output logic [15:0]       stall_count
);
    localparam int         HALF     = DATA_W / 2;
    localparam logic [4:0] NREGS5   = 5'(NUM_REGS);
    localparam logic [3:0] LINK_IDX = 4'(LINK_REG);
    localparam logic [4:0] OP_RET   = 5'b11010;

    typedef struct packed {
        logic       cmp;
        logic       returni;
        logic       mem_addr_sel;
        logic [1:0] sp_sel;
        logic       mem_wr;
        logic       mem_rd;
        logic       wb_sel;
        logic       reg_wr;
        logic       call;
    } ctrl_t;

    typedef struct packed {
        ctrl_t      ctrl;
        logic [1:0] imm_sel;
        logic [1:0] reg_dst_sel;
        logic       branch_sel;
        logic       branch_type;
    } dec_t;

    logic [4:0]        opcode;
    logic [3:0]        rs1, rs2, rd_field, rd1_idx, rd_d;
    dec_t              dec;
    ctrl_t             ctrl_q;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rd1_d, rd2_d, imm_d;
    logic [31:0]       imm32;
    logic              hazard, accept;

    assign opcode   = instr[31:27];
    assign rs1      = instr[26:23];
    assign rs2      = instr[22:19];
    assign rd_field = instr[18:15];
    assign rd1_idx  = (opcode == OP_RET) ? LINK_IDX : rs1;
    assign out_ctrl = ctrl_q;

    always_comb begin
        dec = '0;
        casez (opcode)
            5'b00000: ;
            5'b00???: begin dec.ctrl.reg_wr = 1'b1; dec.reg_dst_sel = 2'b10; end
            5'b01???: begin dec.ctrl.reg_wr = 1'b1; dec.reg_dst_sel = 2'b01; end
            5'b10000: begin
                dec.ctrl.mem_rd = 1'b1; dec.ctrl.wb_sel = 1'b1; dec.ctrl.reg_wr = 1'b1;
                dec.reg_dst_sel = 2'b10;
            end
            5'b10001: dec.ctrl.mem_wr = 1'b1;
            5'b10010: dec.ctrl.cmp = 1'b1;
            5'b10011: begin
                dec.ctrl.mem_wr = 1'b1; dec.ctrl.sp_sel = 2'b01; dec.ctrl.mem_addr_sel = 1'b1;
            end
            5'b10100: begin
                dec.ctrl.mem_rd = 1'b1; dec.ctrl.wb_sel = 1'b1; dec.ctrl.reg_wr = 1'b1;
                dec.ctrl.sp_sel = 2'b10; dec.ctrl.mem_addr_sel = 1'b1;
            end
            5'b11000: begin dec.branch_sel = 1'b1; dec.imm_sel = 2'b10; end
            5'b11001: begin dec.branch_sel = 1'b1; dec.branch_type = 1'b1; dec.imm_sel = 2'b01; end
            5'b11010: dec.ctrl.returni = 1'b1;
            5'b11011: begin
                dec.ctrl.call = 1'b1; dec.branch_sel = 1'b1; dec.branch_type = 1'b1;
                dec.imm_sel = 2'b10;
            end
            default: ;
        endcase
    end

    // A single-half write keeps the other half of the register intact.
    function automatic logic [DATA_W-1:0] merge_wr(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic hi, input logic lo);
        if (hi && !lo)
            return {new_val[DATA_W-1:HALF], old_val[HALF-1:0]};
        else if (lo && !hi)
            return {old_val[DATA_W-1:HALF], new_val[HALF-1:0]};
        else
            return new_val;
    endfunction

    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if ({1'b0, rd1_idx} < NREGS5)
            rd1_d = (wr && wr_dst == rd1_idx) ? merge_wr(regs[rd1_idx], wr_data, wr_hi, wr_lo)
                                              : regs[rd1_idx];
        if ({1'b0, rs2} < NREGS5)
            rd2_d = (wr && wr_dst == rs2) ? merge_wr(regs[rs2], wr_data, wr_hi, wr_lo)
                                          : regs[rs2];
    end

    always_comb begin
        case (dec.imm_sel)
            2'b00:   begin imm_d = DATA_W'($signed(instr[15:0])); imm32 = 32'($signed(instr[15:0])); end
            2'b01:   begin imm_d = DATA_W'($signed(instr[18:0])); imm32 = 32'($signed(instr[18:0])); end
            default: begin imm_d = DATA_W'($signed(instr[26:0])); imm32 = 32'($signed(instr[26:0])); end
        endcase
        case (dec.reg_dst_sel)
            2'b00:   rd_d = rs1;
            2'b01:   rd_d = rs2;
            default: rd_d = rd_field;
        endcase
    end

    assign hazard     = out_valid && ctrl_q.mem_rd && ctrl_q.reg_wr && (out_rd == rs1 || out_rd == rs2);
    assign in_ready   = !flush && !hazard && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign branch_pc  = imm32 + (dec.branch_type ? pc_plus_4 : 32'd0);
    assign branch_sel = accept && dec.branch_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr && {1'b0, wr_dst} < NREGS5) begin
            regs[wr_dst] <= merge_wr(regs[wr_dst], wr_data, wr_hi, wr_lo);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_opcode    <= '0;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_rd        <= '0;
            out_rd1       <= '0;
            out_rd2       <= '0;
            out_imm       <= '0;
            out_pc_plus_4 <= '0;
            out_interrupt <= 1'b0;
            ctrl_q        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_opcode    <= opcode;
            out_rs1       <= rs1;
            out_rs2       <= rs2;
            out_rd        <= rd_d;
            out_rd1       <= rd1_d;
            out_rd2       <= rd2_d;
            out_imm       <= imm_d;
            out_pc_plus_4 <= pc_plus_4;
            out_interrupt <= interrupt;
            ctrl_q        <= dec.ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (in_valid && hazard && !flush && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
endmodule

// File: tb/tb_id_stage_p.sv
// Bench for id_stage_p: directed scenarios then random traffic against a behavioural model.
module tb_id_stage_p;
    localparam int DW = 32;
    localparam int NR = 12;
    localparam int LR = 11;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, interrupt, wr, wr_hi, wr_lo, flush;
    logic [31:0]   instr, pc_plus_4;
    logic [3:0]    wr_dst;
    logic [DW-1:0] wr_data;
    logic          out_valid, out_ready, out_interrupt, branch_sel;
    logic [4:0]    out_opcode;
    logic [3:0]    out_rs1, out_rs2, out_rd;
    logic [DW-1:0] out_rd1, out_rd2, out_imm;
    logic [31:0]   out_pc_plus_4, branch_pc;
    logic [9:0]    out_ctrl;
    logic [15:0]   stall_count;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    logic [31:0] m_regs [NR];
    bit          m_ov, m_int;
    int          m_op, m_rs1, m_rs2, m_rd;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc;
    logic [9:0]  m_ctrl;
    logic [15:0] m_stall;

    id_stage_p #(.DATA_W(DW), .NUM_REGS(NR), .LINK_REG(LR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .pc_plus_4(pc_plus_4), .interrupt(interrupt), .wr(wr), .wr_dst(wr_dst), .wr_data(wr_data),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm), .out_pc_plus_4(out_pc_plus_4),
        .out_interrupt(out_interrupt), .out_ctrl(out_ctrl), .branch_pc(branch_pc),
        .branch_sel(branch_sel), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ctrl bits: cmp returni mem_addr_sel sp_sel[1:0] mem_wr mem_rd wb_sel reg_wr call
    function automatic void tdec(input int op, output logic [9:0] c, output int isel,
                                 output int dsel, output bit br, output bit bt);
        c = 10'h000; isel = 0; dsel = 0; br = 0; bt = 0;
        if (op >= 1 && op <= 7)        begin c = 10'h002; dsel = 2; end
        else if (op >= 8 && op <= 15)  begin c = 10'h002; dsel = 1; end
        else if (op == 16)             begin c = 10'h00E; dsel = 2; end
        else if (op == 17)             c = 10'h010;
        else if (op == 18)             c = 10'h200;
        else if (op == 19)             c = 10'h0B0;
        else if (op == 20)             c = 10'h0CE;
        else if (op == 24)             begin br = 1; isel = 2; end
        else if (op == 25)             begin br = 1; bt = 1; isel = 1; end
        else if (op == 26)             c = 10'h100;
        else if (op == 27)             begin c = 10'h001; br = 1; bt = 1; isel = 2; end
    endfunction

    function automatic longint sx(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    // value register idx holds once this cycle's writeback has landed
    function automatic logic [31:0] m_after(input int idx);
        logic [31:0] old = m_regs[idx];
        if (!wr || int'(wr_dst) != idx) return old;
        if (wr_hi && !wr_lo) return (wr_data & 32'hFFFF_0000) | (old & 32'h0000_FFFF);
        if (wr_lo && !wr_hi) return (old & 32'hFFFF_0000) | (wr_data & 32'h0000_FFFF);
        return wr_data;
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        if (idx >= NR) return 32'h0;
        return m_after(idx);
    endfunction

    function automatic logic [31:0] mk(input int op, input int r1, input int r2, input int rd, input int low);
        return {5'(op), 4'(r1), 4'(r2), 4'(rd), 15'(low)};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        m_ov = 0; m_int = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_ctrl = 0; m_stall = 0;
    endtask

    task automatic set_idle();
        in_valid = 0; wr = 0; wr_hi = 0; wr_lo = 0; flush = 0; out_ready = 1;
        interrupt = 0; instr = 0; pc_plus_4 = 0; wr_data = 0; wr_dst = 0;
    endtask

    task automatic check_outs();
        chk("out_valid", out_valid, m_ov);
        chk("out_opcode", out_opcode, m_op);
        chk("out_rs1", out_rs1, m_rs1);
        chk("out_rs2", out_rs2, m_rs2);
        chk("out_rd", out_rd, m_rd);
        chk("out_rd1", out_rd1, m_rd1);
        chk("out_rd2", out_rd2, m_rd2);
        chk("out_imm", out_imm, m_imm);
        chk("out_pc_plus_4", out_pc_plus_4, m_pc);
        chk("out_interrupt", out_interrupt, m_int);
        chk("out_ctrl", out_ctrl, m_ctrl);
        chk("stall_count", stall_count, m_stall);
    endtask

    // inputs are driven at negedge; comb outputs checked just after, registered ones at next negedge
    task automatic cycle();
        logic [9:0]  c;
        int          isel, dsel, op, r1, r2, rf, dst;
        bit          br, bt, hz, rdy, acc;
        longint      raw, imm, s;
        logic [31:0] bpc, e1, e2;
        logic [31:0] nregs [NR];
        #1;
        op = int'(instr[31:27]); r1 = int'(instr[26:23]); r2 = int'(instr[22:19]); rf = int'(instr[18:15]);
        tdec(op, c, isel, dsel, br, bt);
        hz  = m_ov && m_ctrl[3] && m_ctrl[1] && (m_rd == r1 || m_rd == r2);
        rdy = !flush && !hz && (!m_ov || out_ready);
        acc = in_valid && rdy;
        if (isel == 0)      begin raw = longint'(instr[15:0]); imm = sx(raw, 16); end
        else if (isel == 1) begin raw = longint'(instr[18:0]); imm = sx(raw, 19); end
        else                begin raw = longint'(instr[26:0]); imm = sx(raw, 27); end
        s   = imm + (bt ? longint'(pc_plus_4) : 64'sd0);
        bpc = s[31:0];
        dst = (dsel == 0) ? r1 : (dsel == 1) ? r2 : rf;
        e1  = m_read(op == 26 ? LR : r1);
        e2  = m_read(r2);
        chk("in_ready", in_ready, rdy);
        chk("branch_sel", branch_sel, acc && br);
        chk("branch_pc", branch_pc, bpc);
        for (int i = 0; i < NR; i++) nregs[i] = m_after(i);
        @(posedge clk);
        for (int i = 0; i < NR; i++) m_regs[i] = nregs[i];
        if (in_valid && hz && !flush && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (flush) m_ov = 0;
        else if (acc) begin
            m_ov = 1; m_op = op; m_rs1 = r1; m_rs2 = r2; m_rd = dst; m_rd1 = e1; m_rd2 = e2;
            m_imm = imm[31:0]; m_pc = pc_plus_4; m_int = interrupt; m_ctrl = c;
        end else if (out_ready) m_ov = 0;
        @(negedge clk);
        check_outs();
    endtask

    initial begin
        rst_n = 0;
        set_idle();
        m_reset();
        #2;
        check_outs();
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;

        // half-word write of R3
        wr = 1; wr_dst = 3; wr_data = 32'h1234_5678; cycle();
        wr_hi = 1; wr_data = 32'hAAAA_0000; cycle();
        set_idle(); in_valid = 1; instr = mk(1, 3, 0, 1, 0); cycle();
        chk("r030_hi_write", out_rd1, 32'hAAAA_5678);

        // same-cycle writeback bypass
        set_idle(); in_valid = 1; instr = mk(1, 0, 5, 2, 0);
        wr = 1; wr_dst = 5; wr_data = 32'h55; cycle();
        chk("r031_bypass", out_rd2, 32'h55);

        // load-use hazard
        set_idle(); in_valid = 1; instr = mk(16, 0, 0, 4, 0); cycle();
        instr = mk(1, 4, 0, 1, 0);
        #1 chk("r032_in_ready", in_ready, 0);
        cycle();
        chk("r032_stall", stall_count, 1);
        chk("r032_bubble", out_valid, 0);
        cycle();
        chk("r032_accept", out_valid, 1);
        chk("r032_rs1", out_rs1, 4);

        // backpressure hold
        out_ready = 0; instr = mk(2, 6, 7, 8, 16'h123);
        for (int k = 0; k < 3; k++) begin
            #1 chk("r033_in_ready", in_ready, 0);
            cycle();
            chk("r033_hold_op", out_opcode, 1);
            chk("r033_hold_rs1", out_rs1, 4);
        end
        out_ready = 1; cycle();
        chk("r033_op", out_opcode, 2);
        chk("r033_rs1", out_rs1, 6);

        // flush beats accept and hold
        flush = 1; out_ready = 0; in_valid = 1; instr = mk(24, 1, 2, 3, 16'h40);
        #1 chk("r034_branch_sel", branch_sel, 0);
        cycle();
        chk("r034_out_valid", out_valid, 0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            instr     = $urandom;
            if ($urandom_range(0, 2) == 0) instr[31:27] = 5'($urandom_range(16, 27));
            if ($urandom_range(0, 3) == 0) instr[26:23] = 4'(m_rd);
            pc_plus_4 = $urandom;
            interrupt = 1'($urandom_range(0, 1));
            wr        = 1'($urandom_range(0, 1));
            wr_dst    = 4'($urandom_range(0, 15));
            wr_data   = $urandom;
            wr_hi     = 1'($urandom_range(0, 1));
            wr_lo     = 1'($urandom_range(0, 1));
            cycle();
        end

        // asynchronous reset mid-stream
        set_idle(); in_valid = 1; instr = mk(3, 1, 2, 3, 7); cycle();
        chk("r035_pre_valid", out_valid, 1);
        set_idle();
        #2 rst_n = 0;
        #1;
        m_reset();
        check_outs();
        chk("r035_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < NR; i++) begin
            in_valid = 1; instr = mk(1, i, i, 0, 0); cycle();
            chk("r035_reg_zero", out_rd1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
